// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the 8-bit CPU register file.
// Register indices R0..R3 give the decoder and benches symbolic names for the write address.
package cpu_pkg;

   localparam int DATA_W    = 8;
   localparam int NUM_REGS  = 4;
   localparam int REG_IDX_W = $clog2(NUM_REGS);
   localparam int RD_ADDR_W = 1;

   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [RD_ADDR_W-1:0] rd_addr_t;

   localparam reg_idx_t R0 = 2'd0;
   localparam reg_idx_t R1 = 2'd1;
   localparam reg_idx_t R2 = 2'd2;
   localparam reg_idx_t R3 = 2'd3;

   // Read operands reach only the low registers, so widen them with zeros.
   function automatic reg_idx_t rd_to_idx(input rd_addr_t addr);
      return reg_idx_t'(addr);
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Operand/write bus between the instruction decoder, control FSM and the register file.
interface register_file_if;
   import cpu_pkg::*;

   reg_idx_t Register_Destination;
   rd_addr_t Register_1_operand;
   rd_addr_t Register_2_operand;
   logic     write_enable;
   data_t    data_in;
   data_t    data_out1;
   data_t    data_out2;

   modport master (
      output Register_Destination, Register_1_operand, Register_2_operand,
      output write_enable, data_in,
      input  data_out1, data_out2
   );

   modport slave (
      input  Register_Destination, Register_1_operand, Register_2_operand,
      input  write_enable, data_in,
      output data_out1, data_out2
   );

endinterface

// File: rtl/reg_cell.sv
// One register of the file: async active-high clear, loads d when load is high.
module reg_cell #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/register_file.sv
// 4 x 8-bit register file: one synchronous write port, two combinational read ports.
// BYPASS=1 forwards data_in to a read port addressing the register being written.
module register_file
   import cpu_pkg::*;
#(
   parameter bit BYPASS = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  bus
);

   logic [NUM_REGS-1:0] load;
   data_t               regs [NUM_REGS];
   reg_idx_t            idx1;
   reg_idx_t            idx2;
   logic                hit1;
   logic                hit2;

   // One-hot write decode; exactly one cell loads when write_enable is high.
   always_comb begin
      load = '0;
      if (bus.write_enable)
         load[bus.Register_Destination] = 1'b1;
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
      reg_cell #(.W(DATA_W)) u_cell (
         .clk  (clk),
         .rst  (rst),
         .load (load[i]),
         .d    (bus.data_in),
         .q    (regs[i])
      );
   end

   assign idx1 = rd_to_idx(bus.Register_1_operand);
   assign idx2 = rd_to_idx(bus.Register_2_operand);

   // Forwarding is suppressed during reset so the ports still read zero.
   assign hit1 = BYPASS && !rst && bus.write_enable && (bus.Register_Destination == idx1);
   assign hit2 = BYPASS && !rst && bus.write_enable && (bus.Register_Destination == idx2);

   assign bus.data_out1 = hit1 ? bus.data_in : regs[idx1];
   assign bus.data_out2 = hit2 ? bus.data_in : regs[idx2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance without and one with read-during-write bypass.
module tb_register_file;
   import cpu_pkg::*;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   register_file_if bus0 ();
   register_file_if bus1 ();

   register_file #(.BYPASS(1'b0)) dut_nobyp (.clk(clk), .rst(rst), .bus(bus0));
   register_file #(.BYPASS(1'b1)) dut_byp   (.clk(clk), .rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Both instances always see identical stimulus.
   task automatic applyStimulus(input reg_idx_t dest, input rd_addr_t a1, input rd_addr_t a2,
                                input logic we, input data_t din);
      bus0.Register_Destination = dest; bus1.Register_Destination = dest;
      bus0.Register_1_operand   = a1;   bus1.Register_1_operand   = a1;
      bus0.Register_2_operand   = a2;   bus1.Register_2_operand   = a2;
      bus0.write_enable         = we;   bus1.write_enable         = we;
      bus0.data_in              = din;  bus1.data_in              = din;
   endtask

   task automatic write_reg(input reg_idx_t dest, input data_t din);
      @(negedge clk);
      applyStimulus(dest, 1'b0, 1'b1, 1'b1, din);
      @(posedge clk);
      #1;
      applyStimulus(dest, 1'b0, 1'b1, 1'b0, din);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      applyStimulus(R0, 1'b0, 1'b1, 1'b0, 8'h00);
      #2;
      tests_run++;
      if (bus0.data_out1 !== 8'h00 || bus0.data_out2 !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_init: got %h/%h expected 00/00", bus0.data_out1, bus0.data_out2);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_read;
      write_reg(R0, 8'hA5);
      write_reg(R1, 8'h3C);
      @(negedge clk);
      applyStimulus(R0, 1'b1, 1'b0, 1'b0, 8'h00);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'h3C || bus0.data_out2 !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL swap_read: got %h/%h expected 3C/A5", bus0.data_out1, bus0.data_out2);
      end
      applyStimulus(R0, 1'b0, 1'b1, 1'b0, 8'h00);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL read_r0: got %h expected A5", bus0.data_out1);
      end
      tests_run++;
      if (bus0.data_out2 !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL read_r1: got %h expected 3C", bus0.data_out2);
      end
   endtask

   task automatic test_write_disabled;
      @(negedge clk);
      applyStimulus(R0, 1'b0, 1'b1, 1'b0, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL we_low_r0: got %h expected A5", bus0.data_out1);
      end
      tests_run++;
      if (bus1.data_out1 !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL we_low_r0_byp: got %h expected A5", bus1.data_out1);
      end
   endtask

   task automatic test_isolation;
      write_reg(R2, 8'h77);
      write_reg(R3, 8'h88);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'hA5 || bus0.data_out2 !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL isolation: got %h/%h expected A5/3C", bus0.data_out1, bus0.data_out2);
      end
      tests_run++;
      if (bus1.data_out1 !== 8'hA5 || bus1.data_out2 !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL isolation_byp: got %h/%h expected A5/3C", bus1.data_out1, bus1.data_out2);
      end
   endtask

   task automatic test_same_reg;
      @(negedge clk);
      applyStimulus(R0, 1'b1, 1'b1, 1'b0, 8'h00);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'h3C || bus0.data_out2 !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL same_r1: got %h/%h expected 3C/3C", bus0.data_out1, bus0.data_out2);
      end
      applyStimulus(R0, 1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'hA5 || bus0.data_out2 !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL same_r0: got %h/%h expected A5/A5", bus0.data_out1, bus0.data_out2);
      end
   endtask

   task automatic test_read_during_write;
      @(negedge clk);
      applyStimulus(R1, 1'b1, 1'b0, 1'b1, 8'h5A);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL rdw_old: got %h expected 3C", bus0.data_out1);
      end
      tests_run++;
      if (bus1.data_out1 !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL rdw_bypass: got %h expected 5A", bus1.data_out1);
      end
      tests_run++;
      if (bus1.data_out2 !== 8'hA5) begin
         tests_failed++;
         $display("[TB] FAIL rdw_bypass_other: got %h expected A5", bus1.data_out2);
      end
      @(posedge clk);
      #1;
      applyStimulus(R1, 1'b1, 1'b0, 1'b0, 8'h00);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL rdw_new: got %h expected 5A", bus0.data_out1);
      end
      tests_run++;
      if (bus1.data_out1 !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL rdw_new_byp: got %h expected 5A", bus1.data_out1);
      end
   endtask

   task automatic test_reset_midrun;
      @(negedge clk);
      applyStimulus(R1, 1'b0, 1'b1, 1'b1, 8'hEE);
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'h00 || bus0.data_out2 !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_async: got %h/%h expected 00/00", bus0.data_out1, bus0.data_out2);
      end
      tests_run++;
      if (bus1.data_out1 !== 8'h00 || bus1.data_out2 !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_async_byp: got %h/%h expected 00/00", bus1.data_out1, bus1.data_out2);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus0.data_out2 !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL reset_ignores_write: got %h expected 00", bus0.data_out2);
      end
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(R0, 1'b0, 1'b1, 1'b1, 8'h11);
      @(posedge clk);
      #1;
      applyStimulus(R0, 1'b0, 1'b1, 1'b0, 8'h00);
      #1;
      tests_run++;
      if (bus0.data_out1 !== 8'h11 || bus0.data_out2 !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_write: got %h/%h expected 11/00", bus0.data_out1, bus0.data_out2);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_write_read();
      test_write_disabled();
      test_isolation();
      test_same_reg();
      test_read_during_write();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
